// File: rtl/gpio_pcint.sv
// Port D pin-change / external-interrupt controller: synchronises pins, latches
// sticky flags, raises irq lines and exposes two control words on the memory bus.
module gpio_pcint #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    input  logic [7:0]  gpio_pin_in_d,
    output logic        irq_pcint,
    output logic        irq_int0,
    output logic        irq_int1
);

    localparam int unsigned PIN_W = 8;
    localparam int unsigned INT_N = 2;

    logic [SYNC_STAGES-1:0][PIN_W-1:0] sync_q;
    logic [PIN_W-1:0] prev_q;
    logic [PIN_W-1:0] pin_s;
    logic [PIN_W-1:0] edges;

    logic             pcie_q;
    logic [PIN_W-1:0] pcmsk_q;
    logic             pcif_q;
    logic [3:0]       eicra_q;
    logic [INT_N-1:0] eimsk_q;
    logic [INT_N-1:0] eifr_q;

    logic             sel0;
    logic             sel1;
    logic             accept;
    logic             wr0;
    logic             wr1;
    logic             pcif_set;
    logic             pcif_clr;
    logic             pcif_d;
    logic [INT_N-1:0] int_set;
    logic [INT_N-1:0] int_level;
    logic [INT_N-1:0] eifr_clr;
    logic [INT_N-1:0] eifr_d;
    logic [INT_N-1:0] eifr_rd;
    logic [31:0]      rd_word;
    logic             unused_bits;

    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:18], mem_wdata[7:4], mem_wstrb[3]};

    // Pin synchroniser plus the 'prev' stage used for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_pin_in_d;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pin_s = sync_q[SYNC_STAGES-1];
    assign edges = pin_s ^ prev_q;

    assign sel0   = (mem_addr[31:2] == BASE_ADDR[31:2]);
    assign sel1   = (mem_addr[31:2] == 30'(BASE_ADDR[31:2] + 30'd1));
    assign accept = mem_valid & (sel0 | sel1) & ~mem_ready;
    assign wr0    = accept & sel0;
    assign wr1    = accept & sel1;

    // INTn sense decode; level-low mode reads the live pin instead of the latch
    always_comb begin
        int_set   = '0;
        int_level = '0;
        for (int n = 0; n < int'(INT_N); n++) begin
            case (eicra_q[2*n +: 2])
                2'b00:   int_level[n] = 1'b1;
                2'b01:   int_set[n]   = edges[2+n];
                2'b10:   int_set[n]   = edges[2+n] & ~pin_s[2+n];
                default: int_set[n]   = edges[2+n] & pin_s[2+n];
            endcase
        end
    end

    assign eifr_rd  = (int_level & ~pin_s[3:2]) | (~int_level & eifr_q);

    // A set in the same cycle as a write-one-to-clear keeps the flag
    assign pcif_set = |(edges & pcmsk_q);
    assign pcif_clr = wr0 & mem_wstrb[2] & mem_wdata[16];
    assign pcif_d   = pcif_set | (pcif_q & ~pcif_clr);
    assign eifr_clr = {INT_N{wr1 & mem_wstrb[2]}} & mem_wdata[17:16];
    assign eifr_d   = int_set | (eifr_q & ~eifr_clr);

    always_comb begin
        rd_word = '0;
        if (sel0) begin
            rd_word = {8'h00, 7'h00, pcif_q, pcmsk_q, 7'h00, pcie_q};
        end else if (sel1) begin
            rd_word = {8'h00, 6'h00, eifr_rd, 6'h00, eimsk_q, 4'h0, eicra_q};
        end
    end

    // Control registers, flags and registered bus/irq outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pcie_q    <= 1'b0;
            pcmsk_q   <= '0;
            pcif_q    <= 1'b0;
            eicra_q   <= '0;
            eimsk_q   <= '0;
            eifr_q    <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            irq_pcint <= 1'b0;
            irq_int0  <= 1'b0;
            irq_int1  <= 1'b0;
        end else begin
            if (wr0 && mem_wstrb[0]) pcie_q  <= mem_wdata[0];
            if (wr0 && mem_wstrb[1]) pcmsk_q <= mem_wdata[15:8];
            if (wr1 && mem_wstrb[0]) eicra_q <= mem_wdata[3:0];
            if (wr1 && mem_wstrb[1]) eimsk_q <= mem_wdata[9:8];
            pcif_q    <= pcif_d;
            eifr_q    <= eifr_d;
            mem_ready <= accept;
            mem_rdata <= accept ? rd_word : 32'h0;
            irq_pcint <= pcif_q & pcie_q;
            irq_int0  <= eifr_rd[0] & eimsk_q[0];
            irq_int1  <= eifr_rd[1] & eimsk_q[1];
        end
    end

endmodule

// File: tb/tb_gpio_pcint.sv
// Bench for gpio_pcint: bus reads are scored against a queue of expected words,
// irq levels and bus corner cases are checked against constants.
module tb_gpio_pcint;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [7:0]  pins;
    logic        irq_pcint;
    logic        irq_int0;
    logic        irq_int1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    gpio_pcint #(.BASE_ADDR(BASE), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .gpio_pin_in_d(pins),
        .irq_pcint(irq_pcint), .irq_int0(irq_int0), .irq_int1(irq_int1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus transaction; reads push their expectation and pop it at mem_ready
    task automatic bus_xfer(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [31:0] exp);
        bit got;
        int n;
        logic [31:0] e;
        if (wstrb == 4'h0) exp_q.push_back(exp);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        got = 1'b0;
        n = 0;
        while (!got && n < 6) begin
            @(posedge clk);
            #1;
            if (mem_ready) got = 1'b1;
            n++;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        if (!got) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            if (wstrb == 4'h0 && exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            if (wstrb == 4'h0) begin
                e = exp_q.pop_front();
                check(tag, mem_rdata, e);
            end
            @(posedge clk);
            #1;
            check({tag, "_ready_pulse"}, 32'(mem_ready), 32'd0);
        end
    endtask

    task automatic miss_access(input string tag, input logic [3:0] wstrb);
        logic seen;
        logic [31:0] rd_or;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h8;
        mem_wdata = 32'hFFFF_FFFF;
        mem_wstrb = wstrb;
        seen  = 1'b0;
        rd_or = '0;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen  = seen | mem_ready;
            rd_or = rd_or | mem_rdata;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        check({tag, "_ready"}, 32'(seen), 32'd0);
        check({tag, "_rdata"}, rd_or, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = 4'h0;
        pins      = 8'hFF;
        cycles(3);
        rst = 1'b0;
        cycles(4);

        check("rst_irq_pcint", 32'(irq_pcint), 32'd0);
        check("rst_irq_int0", 32'(irq_int0), 32'd0);
        check("rst_irq_int1", 32'(irq_int1), 32'd0);
        check("rst_ready", 32'(mem_ready), 32'd0);
        bus_xfer("rst_rd0", BASE, '0, 4'h0, 32'h0);
        bus_xfer("rst_rd4", BASE + 32'h4, '0, 4'h0, 32'h0);

        // Pin-change: PCMSK=0x10, PCIE=1
        pins[4] = 1'b0;
        cycles(5);
        bus_xfer("cfg_pc", BASE, 32'h0000_1001, 4'b0011, '0);
        bus_xfer("rd_pc_cfg", BASE, '0, 4'h0, 32'h0000_1001);
        @(posedge clk);
        #1;
        pins[4] = 1'b1;
        cycles(3);
        check("pcint_lat3", 32'(irq_pcint), 32'd0);
        cycles(1);
        check("pcint_lat4", 32'(irq_pcint), 32'd1);
        bus_xfer("rd_pcif_set", BASE, '0, 4'h0, 32'h0001_1001);

        bus_xfer("w1c_pcif", BASE, 32'h0001_0000, 4'b0100, '0);
        check("pcint_cleared", 32'(irq_pcint), 32'd0);
        bus_xfer("rd_pcif_clr", BASE, '0, 4'h0, 32'h0000_1001);

        pins[5] = 1'b0;
        cycles(6);
        check("pin5_no_irq", 32'(irq_pcint), 32'd0);
        bus_xfer("rd_pin5", BASE, '0, 4'h0, 32'h0000_1001);

        // W1C accepted on the same edge the new pin4 edge sets PCIF
        @(posedge clk);
        #1;
        pins[4] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        bus_xfer("w1c_race", BASE, 32'h0001_0000, 4'b0100, '0);
        bus_xfer("rd_race", BASE, '0, 4'h0, 32'h0001_1001);
        check("race_irq", 32'(irq_pcint), 32'd1);
        bus_xfer("w1c_pcif2", BASE, 32'h0001_0000, 4'b0100, '0);

        // INT0 rising edge
        bus_xfer("cfg_int0", BASE + 32'h4, 32'h0000_0103, 4'b0011, '0);
        pins[2] = 1'b0;
        cycles(6);
        check("int0_fall_ignored", 32'(irq_int0), 32'd0);
        bus_xfer("rd_int0_none", BASE + 32'h4, '0, 4'h0, 32'h0000_0103);
        pins[2] = 1'b1;
        cycles(6);
        check("int0_rise", 32'(irq_int0), 32'd1);
        bus_xfer("rd_int0_set", BASE + 32'h4, '0, 4'h0, 32'h0001_0103);
        bus_xfer("w1c_eifr0", BASE + 32'h4, 32'h0001_0000, 4'b0100, '0);
        bus_xfer("rd_int0_clr", BASE + 32'h4, '0, 4'h0, 32'h0000_0103);
        check("int0_cleared", 32'(irq_int0), 32'd0);

        // INT1 level-low
        bus_xfer("cfg_int1", BASE + 32'h4, 32'h0000_0200, 4'b0011, '0);
        pins[3] = 1'b0;
        cycles(6);
        check("int1_level", 32'(irq_int1), 32'd1);
        bus_xfer("rd_int1_lvl", BASE + 32'h4, '0, 4'h0, 32'h0002_0200);
        bus_xfer("w1c_eifr1", BASE + 32'h4, 32'h0002_0000, 4'b0100, '0);
        bus_xfer("rd_int1_w1c", BASE + 32'h4, '0, 4'h0, 32'h0002_0200);
        check("int1_held", 32'(irq_int1), 32'd1);
        @(posedge clk);
        #1;
        pins[3] = 1'b1;
        cycles(4);
        check("int1_release", 32'(irq_int1), 32'd0);

        // Unmapped address: no handshake, no side effects
        miss_access("miss_rd", 4'h0);
        miss_access("miss_wr", 4'hF);
        bus_xfer("rd_after_mis0", BASE, '0, 4'h0, 32'h0000_1001);
        bus_xfer("rd_after_mis4", BASE + 32'h4, '0, 4'h0, 32'h0000_0200);

        // Reset while a read is completing
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE;
        mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        check("pend_ready", 32'(mem_ready), 32'd1);
        rst       = 1'b1;
        mem_valid = 1'b0;
        cycles(1);
        check("rst_drop_ready", 32'(mem_ready), 32'd0);
        check("rst_drop_rdata", mem_rdata, 32'd0);
        cycles(1);
        rst = 1'b0;
        cycles(4);
        check("rst2_irq_int1", 32'(irq_int1), 32'd0);
        bus_xfer("rst2_rd0", BASE, '0, 4'h0, 32'h0);
        bus_xfer("rst2_rd4", BASE + 32'h4, '0, 4'h0, 32'h0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
